// File: rtl/misc_pipe.sv
// misc_pipe: three-stage arithmetic pipeline with valid/ready handshake and
// one global stall. Stage 1 forms sums/differences, stage 2 the products,
// and stage 3 the two output results.
//
// Parameters:
//   NA  width of A, C, XOUT1, XOUT2 (4..32)
//   NB  width of B (1..NA), zero-extended to NA bits wherever used
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous active-high reset
//   A, B, C    operands, taken when IN_VALID & IN_READY
//   IN_VALID   operands valid this cycle
//   IN_READY   pipeline advances this cycle (also 1 during reset)
//   OUT_VALID  XOUT1/XOUT2 hold a result
//   OUT_READY  consumer takes the result this cycle
//   XOUT1      (na - ((m1-1) - (na+m3))) + zz, modulo 2^NA
//   XOUT2      na + C + 5, wrapped to NA bits (saturated when
//              MISC_PIPE_SAT_EN is defined)
//   OVF        sticky: some result's XOUT2 sum exceeded 2^NA-1
// Build option: define MISC_PIPE_SAT_EN to saturate XOUT2 instead of wrapping.
module misc_pipe #(
  parameter int unsigned NA = 8,
  parameter int unsigned NB = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [NA-1:0] A,
  input  logic [NB-1:0] B,
  input  logic [NA-1:0] C,
  input  logic          IN_VALID,
  output logic          IN_READY,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [NA-1:0] XOUT1,
  output logic [NA-1:0] XOUT2,
  output logic          OVF
);

  localparam logic [NA:0]   CS_OFS  = (NA+1)'(5);
  localparam logic [NA-1:0] AEQ_VAL = {1'b0, {(NA-1){1'b1}}};

  // Single stall condition shared by every stage.
  logic adv;
  assign adv      = OUT_READY | ~OUT_VALID;
  assign IN_READY = RST | adv;

  // Stage 1 combinational terms
  logic [NA-1:0] b_ext, sum_ab, dif_ab;
  logic          sel;
  always_comb begin
    b_ext  = NA'(B);
    sum_ab = A + b_ext;
    dif_ab = A - b_ext;
    sel    = A > b_ext;
  end

  // Stage 1 registers; sel is consumed here, folded into p0/p1.
  logic          v1, aeq1;
  logic [NA-1:0] nb1, na1, p0_1, p1_1, ab1;
  logic [NA:0]   cs1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      v1 <= 1'b0;
    end else if (adv) begin
      v1 <= IN_VALID;
      if (IN_VALID) begin
        nb1  <= sum_ab;
        na1  <= dif_ab;
        p0_1 <= sel ? sum_ab : dif_ab;
        p1_1 <= sel ? A : sum_ab;
        cs1  <= {1'b0, C} + CS_OFS;
        aeq1 <= (A == AEQ_VAL);
        ab1  <= A * b_ext;
      end
    end
  end

  // Stage 2 registers
  logic          v2;
  logic [NA-1:0] na2, m1, m3, zz;
  logic [NA+1:0] s2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      v2 <= 1'b0;
    end else if (adv) begin
      v2 <= v1;
      if (v1) begin
        na2 <= na1;
        m1  <= na1 * nb1;
        m3  <= nb1 * NA'(3);
        zz  <= aeq1 ? ab1 : p0_1 * p1_1;
        s2  <= {2'b00, na1} + {1'b0, cs1};
      end
    end
  end

  // Stage 3 combinational results
  logic [NA-1:0] x1_next, x2_next;
  logic          s2_ovf;
  always_comb begin
    s2_ovf  = |s2[NA+1:NA];
    x1_next = (na2 - ((m1 - NA'(1)) - (na2 + m3))) + zz;
`ifdef MISC_PIPE_SAT_EN
    x2_next = s2_ovf ? '1 : s2[NA-1:0];
`else
    x2_next = s2[NA-1:0];
`endif
  end

  // Output register: loads only with a real result, so XOUT1/XOUT2 keep
  // their last value while bubbles pass through.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      XOUT1     <= '0;
      XOUT2     <= '0;
      OVF       <= 1'b0;
    end else if (adv) begin
      OUT_VALID <= v2;
      if (v2) begin
        XOUT1 <= x1_next;
        XOUT2 <= x2_next;
        if (s2_ovf) OVF <= 1'b1;
      end
    end
  end

endmodule
